// File: rtl/au_pkg.sv
// Shared definitions for the au_seq_nb multi-cycle arithmetic unit:
// operation codes, FSM state encoding and the opcode width.
package au_pkg;

    localparam int AU_OP_W = 2;

    typedef enum logic [AU_OP_W-1:0] {
        AU_ADD  = 2'd0,
        AU_SUB  = 2'd1,
        AU_MULU = 2'd2,
        AU_DIVU = 2'd3
    } au_op_e;

    typedef enum logic [1:0] {
        AU_IDLE = 2'd0,
        AU_MUL  = 2'd1,
        AU_DIV  = 2'd2,
        AU_DONE = 2'd3
    } au_state_e;

endpackage : au_pkg

// File: rtl/au_div_iter.sv
// Restoring divider datapath, one quotient bit per step.
// start loads dividend/divisor and clears the iteration count; each step
// (while not done) shifts one dividend bit into the partial remainder and
// subtracts the divisor when it fits. done rises after WIDTH steps.
module au_div_iter #(
    parameter int WIDTH = 32
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             step,
    input  logic [WIDTH-1:0] dividend,
    input  logic [WIDTH-1:0] divisor,
    output logic             done,
    output logic [WIDTH-1:0] quotient,
    output logic [WIDTH-1:0] remainder
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    logic [WIDTH-1:0] rem_q, rem_d;
    logic [WIDTH-1:0] quo_q, quo_d;
    logic [WIDTH-1:0] dvs_q, dvs_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [WIDTH:0]   shifted_s;
    logic [WIDTH:0]   diff_s;
    logic             done_s;

    // The quotient register doubles as the dividend shifter: its MSB feeds
    // the remainder while the new quotient bit enters at the LSB.
    assign done_s    = (cnt_q == CNT_W'(WIDTH));
    assign shifted_s = {rem_q, quo_q[WIDTH-1]};
    assign diff_s    = shifted_s - {1'b0, dvs_q};

    // Next-state for one restoring iteration (diff_s MSB set means borrow).
    always_comb begin
        rem_d = rem_q;
        quo_d = quo_q;
        dvs_d = dvs_q;
        cnt_d = cnt_q;
        if (start) begin
            rem_d = {WIDTH{1'b0}};
            quo_d = dividend;
            dvs_d = divisor;
            cnt_d = {CNT_W{1'b0}};
        end else if (step && !done_s) begin
            if (!diff_s[WIDTH]) begin
                rem_d = diff_s[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b1};
            end else begin
                rem_d = shifted_s[WIDTH-1:0];
                quo_d = {quo_q[WIDTH-2:0], 1'b0};
            end
            cnt_d = cnt_q + CNT_W'(1);
        end else begin
            cnt_d = cnt_q;
        end
    end

    // Divider state registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            rem_q <= {WIDTH{1'b0}};
            quo_q <= {WIDTH{1'b0}};
            dvs_q <= {WIDTH{1'b0}};
            cnt_q <= {CNT_W{1'b0}};
        end else begin
            rem_q <= rem_d;
            quo_q <= quo_d;
            dvs_q <= dvs_d;
            cnt_q <= cnt_d;
        end
    end

    assign done      = done_s;
    assign quotient  = quo_q;
    assign remainder = rem_q;

endmodule : au_div_iter

// File: rtl/au_seq_nb.sv
// au_seq_nb: WIDTH-bit unsigned multi-cycle ALU (add, sub, shift-add
// multiply, restoring divide) behind a valid/ready handshake.
// Optional feature: define AU_DIV_EN to build the divider (au_div_iter)
// and the DIV state; without it DIVU completes in one cycle with err=1.
// The MUL state also serves as the one-cycle execute slot for ADD, SUB and
// the single-cycle DIVU cases, so every result is loaded from latched
// operands on the edge that enters DONE.
module au_seq_nb
    import au_pkg::*;
#(
    parameter int WIDTH = 32
) (
    input  logic               clk,
    input  logic               rst,
    input  logic               in_valid,
    output logic               in_ready,
    input  logic [WIDTH-1:0]   a,
    input  logic [WIDTH-1:0]   b,
    input  logic [AU_OP_W-1:0] op,
    output logic               out_valid,
    input  logic               out_ready,
    output logic [WIDTH-1:0]   s,
    output logic [WIDTH-1:0]   hi,
    output logic [WIDTH-1:0]   lo,
    output logic               cout,
    output logic               zero,
    output logic               err
);

    localparam int CNT_W = $clog2(WIDTH + 1);

    au_state_e          state_q, state_d;
    au_op_e             op_q;
    au_op_e             op_in_s;
    logic [WIDTH-1:0]   a_q, b_q;
    logic [CNT_W-1:0]   cnt_q, cnt_d;
    logic [2*WIDTH-1:0] prod_q, prod_d;
    logic [WIDTH:0]     mul_sum_s;
    logic [WIDTH:0]     addsub_sum_s;
    logic [WIDTH-1:0]   b_eff_s;
    logic               sub_s;
    logic               accept_s;
    logic               load_s;
    logic               mul_step_s;

    logic [WIDTH-1:0]   res_s_s, res_hi_s, res_lo_s;
    logic               res_cout_s, res_zero_s, res_err_s;

    logic [WIDTH-1:0]   s_q, hi_q, lo_q;
    logic               cout_q, zero_q, err_q;
    logic               out_valid_q, in_ready_q;

    assign op_in_s  = au_op_e'(op);
    assign accept_s = in_valid && (state_q == AU_IDLE);

    // Add/sub shares one adder: subtract is a + ~b + 1, carry-out = no borrow.
    assign sub_s        = (op_q == AU_SUB);
    assign b_eff_s      = sub_s ? ~b_q : b_q;
    assign addsub_sum_s = {1'b0, a_q} + {1'b0, b_eff_s} + {{WIDTH{1'b0}}, sub_s};

    // Shift-add multiply: add multiplicand into the upper half when the
    // current multiplier bit (product LSB) is set, then shift right.
    assign mul_step_s = (state_q == AU_MUL) && (op_q == AU_MULU) &&
                        (cnt_q != CNT_W'(WIDTH));
    assign mul_sum_s  = {1'b0, prod_q[2*WIDTH-1:WIDTH]} +
                        (prod_q[0] ? {1'b0, a_q} : {(WIDTH+1){1'b0}});

`ifdef AU_DIV_EN
    logic             div_start_s;
    logic             div_step_s;
    logic             div_done_s;
    logic [WIDTH-1:0] div_quo_s;
    logic [WIDTH-1:0] div_rem_s;

    assign div_start_s = accept_s && (op_in_s == AU_DIVU) && (b != {WIDTH{1'b0}});
    assign div_step_s  = (state_q == AU_DIV);

    au_div_iter #(
        .WIDTH (WIDTH)
    ) u_div (
        .clk       (clk),
        .rst       (rst),
        .start     (div_start_s),
        .step      (div_step_s),
        .dividend  (a),
        .divisor   (b),
        .done      (div_done_s),
        .quotient  (div_quo_s),
        .remainder (div_rem_s)
    );
`endif

    // FSM next-state decode and result-load strobe.
    always_comb begin
        state_d = state_q;
        load_s  = 1'b0;
        case (state_q)
            AU_IDLE: begin
                if (accept_s) begin
`ifdef AU_DIV_EN
                    if ((op_in_s == AU_DIVU) && (b != {WIDTH{1'b0}})) begin
                        state_d = AU_DIV;
                    end else begin
                        state_d = AU_MUL;
                    end
`else
                    state_d = AU_MUL;
`endif
                end else begin
                    state_d = AU_IDLE;
                end
            end
            AU_MUL: begin
                if ((op_q != AU_MULU) || (cnt_q == CNT_W'(WIDTH))) begin
                    state_d = AU_DONE;
                    load_s  = 1'b1;
                end else begin
                    state_d = AU_MUL;
                end
            end
            AU_DIV: begin
`ifdef AU_DIV_EN
                if (div_done_s) begin
                    state_d = AU_DONE;
                    load_s  = 1'b1;
                end else begin
                    state_d = AU_DIV;
                end
`else
                state_d = AU_IDLE;
`endif
            end
            AU_DONE: begin
                if (out_ready) begin
                    state_d = AU_IDLE;
                end else begin
                    state_d = AU_DONE;
                end
            end
            default: begin
                state_d = AU_IDLE;
            end
        endcase
    end

    // Multiply datapath: product/multiplier register and iteration count.
    always_comb begin
        cnt_d  = cnt_q;
        prod_d = prod_q;
        if (accept_s) begin
            cnt_d  = {CNT_W{1'b0}};
            prod_d = {{WIDTH{1'b0}}, b};
        end else if (mul_step_s) begin
            cnt_d  = cnt_q + CNT_W'(1);
            prod_d = {mul_sum_s, prod_q[WIDTH-1:1]};
        end else begin
            cnt_d  = cnt_q;
        end
    end

    // Result selection for the value loaded on entry to DONE.
    always_comb begin
        res_s_s    = {WIDTH{1'b0}};
        res_hi_s   = {WIDTH{1'b0}};
        res_lo_s   = {WIDTH{1'b0}};
        res_cout_s = 1'b0;
        res_err_s  = 1'b0;
        res_zero_s = 1'b0;
        if (state_q == AU_DIV) begin
`ifdef AU_DIV_EN
            res_hi_s = div_rem_s;
            res_lo_s = div_quo_s;
`endif
            res_zero_s = (res_hi_s == {WIDTH{1'b0}}) && (res_lo_s == {WIDTH{1'b0}});
        end else begin
            case (op_q)
                AU_ADD, AU_SUB: begin
                    res_s_s    = addsub_sum_s[WIDTH-1:0];
                    res_cout_s = addsub_sum_s[WIDTH];
                end
                AU_MULU: begin
                    res_hi_s = prod_q[2*WIDTH-1:WIDTH];
                    res_lo_s = prod_q[WIDTH-1:0];
                end
                AU_DIVU: begin
`ifdef AU_DIV_EN
                    // Only b == 0 reaches this path when the divider exists.
                    res_hi_s = a_q;
                    res_lo_s = {WIDTH{1'b1}};
`endif
                    res_err_s = 1'b1;
                end
                default: begin
                    res_err_s = 1'b0;
                end
            endcase
            if ((op_q == AU_ADD) || (op_q == AU_SUB)) begin
                res_zero_s = (res_s_s == {WIDTH{1'b0}});
            end else begin
                res_zero_s = (res_hi_s == {WIDTH{1'b0}}) && (res_lo_s == {WIDTH{1'b0}});
            end
        end
    end

    // State, operand latches and registered outputs with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= AU_IDLE;
            op_q        <= AU_ADD;
            a_q         <= {WIDTH{1'b0}};
            b_q         <= {WIDTH{1'b0}};
            cnt_q       <= {CNT_W{1'b0}};
            prod_q      <= {(2*WIDTH){1'b0}};
            s_q         <= {WIDTH{1'b0}};
            hi_q        <= {WIDTH{1'b0}};
            lo_q        <= {WIDTH{1'b0}};
            cout_q      <= 1'b0;
            zero_q      <= 1'b0;
            err_q       <= 1'b0;
            out_valid_q <= 1'b0;
            in_ready_q  <= 1'b1;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            prod_q  <= prod_d;
            if (accept_s) begin
                a_q  <= a;
                b_q  <= b;
                op_q <= op_in_s;
            end
            if (load_s) begin
                s_q    <= res_s_s;
                hi_q   <= res_hi_s;
                lo_q   <= res_lo_s;
                cout_q <= res_cout_s;
                zero_q <= res_zero_s;
                err_q  <= res_err_s;
            end
            out_valid_q <= (state_d == AU_DONE);
            in_ready_q  <= (state_d == AU_IDLE);
        end
    end

    assign in_ready  = in_ready_q;
    assign out_valid = out_valid_q;
    assign s         = s_q;
    assign hi        = hi_q;
    assign lo        = lo_q;
    assign cout      = cout_q;
    assign zero      = zero_q;
    assign err       = err_q;

endmodule : au_seq_nb
